mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage between execute and writeback. Consumes the EX-stage pipeline register (ALU result or address, store data, destination, control). Runs a req/ack handshake with a variable-latency data memory, handling word and byte lanes, and stalls the pipeline until the access completes. Produces the ME-stage register (`ResultRdDat_ME`, `WriteReg_ME`, `RegWrite_ME`) that feeds writeback and the execute-stage bypass network.

## Interface
Parameters:
- `AW`, default 32: data-memory address width; must be ≤32.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous pipeline flush.
- `Result_EX`  in  32  ALU result; byte address for memory operations.
- `WrDat_EX`  in  32  store data.
- `WriteReg_EX`  in  5  destination register.
- `RegWrite_EX`, `MemToReg_EX`, `MemWrite_EX`, `LoadB_EX`, `StoreB_EX`, `InstrVal_EX`  in  1 each  EX control bits.
- `DmReq`  out  1  memory request.
- `DmWe`  out  1  write enable.
- `DmAddr`  out  AW  word-aligned address: `{Result_EX[AW-1:2],2'b00}`.
- `DmWrDat`  out  32  write data, lane-replicated for byte stores.
- `DmByteEn`  out  4  byte-lane enables.
- `DmAck`  in  1  access complete; `DmRdDat` is valid in the same cycle.
- `DmRdDat`  in  32  read data.
- `MemStall_ME`  out  1  stall request, ORed into AnyStall upstream.
- `ResultRdDat_ME`  out  32  loaded data or passed-through ALU result.
- `WriteReg_ME`  out  5  destination register.
- `RegWrite_ME`, `InstrVal_ME`  out  1 each  writeback enable and valid bit.
- `AddrErr_ME`  out  1  misaligned-access flag (only with `MEM_MISALIGN_TRAP_EN`).

## Operation
- Memory op (MemOp) = `InstrVal_EX & (MemToReg_EX | MemWrite_EX)`.
- FSM states: IDLE, BUSY, DRAIN.
  - IDLE with MemOp: `DmReq`=1 combinationally. If `DmAck` arrives the same cycle, the access completes and the FSM stays in IDLE. Otherwise it goes to BUSY.
  - BUSY: `DmReq`=1. `DmAddr`, `DmWe`, `DmWrDat` and `DmByteEn` stay stable, since EX is held by the stall. On `DmAck` the access completes and the FSM goes to IDLE. If `flush` is asserted before the ack, the FSM goes to DRAIN.
  - DRAIN: `DmReq`=1 until `DmAck`, then IDLE. The result is discarded.
- `MemStall_ME` = `(IDLE & MemOp & ~DmAck) | (BUSY & ~DmAck) | DRAIN`.
- Lanes:
  - Word access: `DmByteEn`=4'hF.
  - Byte store (`StoreB_EX`): `DmByteEn` = `4'b0001 << Result_EX[1:0]`; `DmWrDat` = `{4{WrDat_EX[7:0]}}`.
  - Byte load (`LoadB_EX`): select the byte of `DmRdDat` indexed by `Result_EX[1:0]` and sign-extend it to 32 bits.
- `DmWe` = `MemWrite_EX`.
- ME register update each clock:
  - If `flush`, or `MemStall_ME` is high: insert a bubble (all ME outputs 0).
  - Otherwise, capture the EX values. `ResultRdDat_ME` takes the load data when `MemToReg_EX`, else `Result_EX`.
- A store completes with `RegWrite_ME` as carried from EX, normally 0.

## Timing
- Reset: `rst_n` low forces IDLE and all ME outputs to 0, asynchronously. `DmReq`=0 during reset.
- If reset is asserted mid-BUSY, the request is dropped; the memory must tolerate this.
- Latency:
  - Non-memory instruction: 1 cycle from EX to ME.
  - Memory access with N wait cycles before `DmAck`: 1+N cycles; `MemStall_ME` is high for N cycles.
- Zero-wait ack: no stall cycle is generated.
- `DmReq` is held continuously until `DmAck`; there is never more than one outstanding request.
- `flush` and `DmAck` in the same cycle while BUSY: the access completes, the FSM goes to IDLE, and the ME register gets a bubble.
- `flush` in IDLE: no request is issued that cycle (MemOp gated by `~flush`), and the ME register gets a bubble.

## Configuration
- Macro: `MEM_MISALIGN_TRAP_EN`.
- Defined: a word access with `Result_EX[1:0]`≠0 suppresses `DmReq`, generates no stall, forces `RegWrite_ME`=0, and sets `AddrErr_ME`=1 for one cycle in ME.
- Undefined: the low address bits are ignored for word accesses, and `AddrErr_ME` is tied to 0.

## Test plan
- Reset with `rst_n` low mid-BUSY → `DmReq`=0, all ME outputs 0, FSM in IDLE after release.
- ALU op, `Result_EX`=0x1234, `RegWrite_EX`=1, `WriteReg_EX`=5 → next cycle `ResultRdDat_ME`=0x1234, `WriteReg_ME`=5, `RegWrite_ME`=1, no stall.
- Word load, addr 0x100, `DmAck` after 3 cycles with `DmRdDat`=0xCAFEF00D → `MemStall_ME` high for 3 cycles, ME bubbles during the stall, then `ResultRdDat_ME`=0xCAFEF00D.
- Byte load, addr 0x103, `DmRdDat`=0x80112233, zero-wait ack → `ResultRdDat_ME`=0xFFFFFF80.
- Byte store, addr 0x102, `WrDat_EX`=0x000000AB → `DmByteEn`=4'b0100, `DmWrDat`=0xABABABAB, `DmWe`=1.
- `flush` during BUSY, ack 2 cycles later → `DmReq` held through DRAIN until ack, `RegWrite_ME`=0 throughout, stall released after the ack.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: req/ack data-memory handshake with byte lanes and ME register.
// Optional misaligned word-access trap enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_stage #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic [31:0]   Result_EX,
  input  logic [31:0]   WrDat_EX,
  input  logic [4:0]    WriteReg_EX,
  input  logic          RegWrite_EX,
  input  logic          MemToReg_EX,
  input  logic          MemWrite_EX,
  input  logic          LoadB_EX,
  input  logic          StoreB_EX,
  input  logic          InstrVal_EX,
  output logic          DmReq,
  output logic          DmWe,
  output logic [AW-1:0] DmAddr,
  output logic [31:0]   DmWrDat,
  output logic [3:0]    DmByteEn,
  input  logic          DmAck,
  input  logic [31:0]   DmRdDat,
  output logic          MemStall_ME,
  output logic [31:0]   ResultRdDat_ME,
  output logic [4:0]    WriteReg_ME,
  output logic          RegWrite_ME,
  output logic          InstrVal_ME,
  output logic          AddrErr_ME
);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

  state_t      state;
  logic        mem_op_raw;
  logic        misalign;
  logic        mem_op;
  logic        req;
  logic        stall;
  logic [7:0]  ld_byte;
  logic [31:0] ld_dat;

  assign mem_op_raw = InstrVal_EX & (MemToReg_EX | MemWrite_EX) & ~flush;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = mem_op_raw & ~LoadB_EX & ~StoreB_EX & (Result_EX[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign mem_op = mem_op_raw & ~misalign;

  always_comb begin
    req   = 1'b0;
    stall = 1'b0;
    case (state)
      IDLE: begin
        req   = mem_op;
        stall = mem_op & ~DmAck;
      end
      BUSY: begin
        req   = 1'b1;
        stall = ~DmAck;
      end
      DRAIN: begin
        req   = 1'b1;
        stall = 1'b1;
      end
      default: begin
        req   = 1'b0;
        stall = 1'b0;
      end
    endcase
  end

  // Request is gated by reset so an EX-stage memop cannot raise DmReq while in reset.
  assign DmReq       = req & rst_n;
  assign MemStall_ME = stall;
  assign DmWe        = MemWrite_EX;
  assign DmAddr      = {Result_EX[AW-1:2], 2'b00};
  assign DmWrDat     = StoreB_EX ? {4{WrDat_EX[7:0]}} : WrDat_EX;
  assign DmByteEn    = StoreB_EX ? (4'b0001 << Result_EX[1:0]) : 4'hF;

  assign ld_byte = DmRdDat[{Result_EX[1:0], 3'b000} +: 8];
  assign ld_dat  = LoadB_EX ? {{24{ld_byte[7]}}, ld_byte} : DmRdDat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      ResultRdDat_ME <= '0;
      WriteReg_ME    <= '0;
      RegWrite_ME    <= 1'b0;
      InstrVal_ME    <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      AddrErr_ME     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE:    if (mem_op & ~DmAck) state <= BUSY;
        BUSY:    if (DmAck) state <= IDLE;
                 else if (flush) state <= DRAIN;
        DRAIN:   if (DmAck) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (flush | stall) begin
        ResultRdDat_ME <= '0;
        WriteReg_ME    <= '0;
        RegWrite_ME    <= 1'b0;
        InstrVal_ME    <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        AddrErr_ME     <= 1'b0;
`endif
      end else begin
        ResultRdDat_ME <= MemToReg_EX ? ld_dat : Result_EX;
        WriteReg_ME    <= WriteReg_EX;
        RegWrite_ME    <= RegWrite_EX & ~misalign;
        InstrVal_ME    <= InstrVal_EX;
`ifdef MEM_MISALIGN_TRAP_EN
        AddrErr_ME     <= misalign;
`endif
      end
    end
  end

`ifndef MEM_MISALIGN_TRAP_EN
  assign AddrErr_ME = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus random instruction stream
// checked against a transaction-level reference model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [31:0] Result_EX, WrDat_EX;
  logic [4:0]  WriteReg_EX;
  logic        RegWrite_EX, MemToReg_EX, MemWrite_EX, LoadB_EX, StoreB_EX, InstrVal_EX;
  logic        DmReq, DmWe;
  logic [31:0] DmAddr, DmWrDat;
  logic [3:0]  DmByteEn;
  logic        DmAck;
  logic [31:0] DmRdDat;
  logic        MemStall_ME;
  logic [31:0] ResultRdDat_ME;
  logic [4:0]  WriteReg_ME;
  logic        RegWrite_ME, InstrVal_ME, AddrErr_ME;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_stage #(.AW(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .Result_EX(Result_EX), .WrDat_EX(WrDat_EX), .WriteReg_EX(WriteReg_EX),
    .RegWrite_EX(RegWrite_EX), .MemToReg_EX(MemToReg_EX), .MemWrite_EX(MemWrite_EX),
    .LoadB_EX(LoadB_EX), .StoreB_EX(StoreB_EX), .InstrVal_EX(InstrVal_EX),
    .DmReq(DmReq), .DmWe(DmWe), .DmAddr(DmAddr), .DmWrDat(DmWrDat), .DmByteEn(DmByteEn),
    .DmAck(DmAck), .DmRdDat(DmRdDat),
    .MemStall_ME(MemStall_ME), .ResultRdDat_ME(ResultRdDat_ME), .WriteReg_ME(WriteReg_ME),
    .RegWrite_ME(RegWrite_ME), .InstrVal_ME(InstrVal_ME), .AddrErr_ME(AddrErr_ME)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_ex(input int kind, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [4:0] wr);
    Result_EX   = addr;
    WrDat_EX    = wd;
    WriteReg_EX = wr;
    InstrVal_EX = (kind >= 0);
    MemToReg_EX = (kind == 1 || kind == 2);
    MemWrite_EX = (kind == 3 || kind == 4);
    LoadB_EX    = (kind == 2);
    StoreB_EX   = (kind == 4);
    RegWrite_EX = (kind >= 0 && kind <= 2);
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, "_rw"}, 32'(RegWrite_ME), 32'd0);
    chk({tag, "_iv"}, 32'(InstrVal_ME), 32'd0);
    chk({tag, "_dat"}, ResultRdDat_ME, 32'd0);
  endtask

  // Reference: value delivered to writeback for a load, from byte-address arithmetic.
  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [31:0] data,
                                             input bit byte_ld);
    logic [31:0] b;
    int unsigned sh;
    if (!byte_ld) return data;
    sh = 8 * int'(addr[1:0]);
    b  = (data >> sh) & 32'hFF;
    return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
  endfunction

  // kind: -1 bubble, 0 alu, 1 word load, 2 byte load, 3 word store, 4 byte store.
  task automatic run_op(input int kind, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rd, input logic [4:0] wr, input int unsigned n);
    bit          is_mem;
    logic [31:0] exp_res, exp_wd;
    logic [3:0]  exp_be;
    is_mem  = (kind >= 1);
    exp_res = (kind == 1 || kind == 2) ? model_load(addr, rd, kind == 2) : addr;
    exp_be  = (kind == 4) ? 4'(1 << int'(addr[1:0])) : 4'hF;
    exp_wd  = (kind == 4) ? (32'(wd[7:0]) * 32'h0101_0101) : wd;
    set_ex(kind, addr, wd, wr);
    DmRdDat = rd;
    DmAck   = is_mem && (n == 0);
    if (!is_mem) begin
      mid();
      chk("alu_stall", 32'(MemStall_ME), 32'd0);
      chk("alu_req", 32'(DmReq), 32'd0);
      step();
    end else begin
      for (int unsigned c = 0; c <= n; c++) begin
        mid();
        chk("req", 32'(DmReq), 32'd1);
        chk("stall", 32'(MemStall_ME), 32'(c < n));
        chk("we", 32'(DmWe), 32'(kind >= 3));
        chk("addr", DmAddr, addr & 32'hFFFF_FFFC);
        chk("be", 32'(DmByteEn), 32'(exp_be));
        if (kind >= 3) chk("wrdat", DmWrDat, exp_wd);
        step();
        if (c < n) begin
          chk_bubble("stall_me");
          DmAck = (c + 1 == n);
        end
      end
      DmAck = 1'b0;
    end
    chk("me_dat", ResultRdDat_ME, exp_res);
    chk("me_wr", 32'(WriteReg_ME), 32'(wr));
    chk("me_rw", 32'(RegWrite_ME), 32'(kind >= 0 && kind <= 2));
    chk("me_iv", 32'(InstrVal_ME), 32'(kind >= 0));
    chk("me_err", 32'(AddrErr_ME), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          kind;
    logic [31:0] a, w, r;
    rst_n = 1'b0; flush = 1'b0; DmAck = 1'b0; DmRdDat = '0;
    set_ex(-1, '0, '0, '0);
    #12;
    chk("rst_req", 32'(DmReq), 32'd0);
    chk_bubble("rst_me");
    chk("rst_stall", 32'(MemStall_ME), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    run_op(0, 32'h1234, 32'd0, 32'd0, 5'd5, 0);
    run_op(1, 32'h100, 32'd0, 32'hCAFE_F00D, 5'd7, 3);
    run_op(2, 32'h103, 32'd0, 32'h8011_2233, 5'd9, 0);
    run_op(4, 32'h102, 32'h0000_00AB, 32'd0, 5'd0, 0);
    run_op(3, 32'h200, 32'h1357_9BDF, 32'd0, 5'd0, 2);

    // Flush in BUSY, ack two cycles later: DRAIN holds request, result discarded.
    set_ex(1, 32'h300, 32'd0, 5'd3);
    DmRdDat = 32'hDEAD_BEEF;
    mid(); step();
    flush = 1'b1;
    mid();
    chk("fl_req", 32'(DmReq), 32'd1);
    chk("fl_stall", 32'(MemStall_ME), 32'd1);
    step();
    flush = 1'b0;
    set_ex(-1, '0, '0, '0);
    chk_bubble("fl_me0");
    mid();
    chk("drain_req0", 32'(DmReq), 32'd1);
    chk("drain_stall0", 32'(MemStall_ME), 32'd1);
    step();
    chk_bubble("fl_me1");
    DmAck = 1'b1;
    mid();
    chk("drain_req1", 32'(DmReq), 32'd1);
    step();
    DmAck = 1'b0;
    chk_bubble("fl_me2");
    mid();
    chk("drain_done_req", 32'(DmReq), 32'd0);
    chk("drain_done_stall", 32'(MemStall_ME), 32'd0);
    step();

    // Flush and ack together in BUSY: completes, but ME gets a bubble.
    set_ex(1, 32'h400, 32'd0, 5'd4);
    DmRdDat = 32'h1111_2222;
    mid(); step();
    flush = 1'b1; DmAck = 1'b1;
    mid();
    chk("flack_stall", 32'(MemStall_ME), 32'd0);
    step();
    flush = 1'b0; DmAck = 1'b0;
    set_ex(-1, '0, '0, '0);
    chk_bubble("flack_me");
    mid();
    chk("flack_idle_req", 32'(DmReq), 32'd0);
    step();

    // Flush in IDLE: no request issued for the presented memop.
    set_ex(3, 32'h500, 32'h55, 5'd0);
    flush = 1'b1;
    mid();
    chk("flidle_req", 32'(DmReq), 32'd0);
    chk("flidle_stall", 32'(MemStall_ME), 32'd0);
    step();
    flush = 1'b0;
    set_ex(-1, '0, '0, '0);
    chk_bubble("flidle_me");

    // Reset mid-BUSY: request dropped, ME cleared, FSM back in IDLE.
    set_ex(1, 32'h600, 32'd0, 5'd6);
    mid(); step();
    rst_n = 1'b0;
    #1;
    chk("rstb_req", 32'(DmReq), 32'd0);
    chk_bubble("rstb_me");
    set_ex(-1, '0, '0, '0);
    step();
    rst_n = 1'b1;
    mid();
    chk("rstb_idle_req", 32'(DmReq), 32'd0);
    chk("rstb_idle_stall", 32'(MemStall_ME), 32'd0);
    step();

    for (int unsigned i = 0; i < 60; i++) begin
      kind = int'($urandom_range(0, 4));
      a    = $urandom;
      if (kind == 1 || kind == 3) a[1:0] = 2'b00;
      w    = $urandom;
      r    = $urandom;
      run_op(kind, a, w, r, 5'($urandom_range(0, 31)), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
